v5_filter_ctrl: RTL and testbench

- Sequencer and event extractor for the v5 trapezoidal shaping filter.
- Clears and settles the filter after enable, then arms a threshold trigger on the filter output.
- Samples the pulse amplitude at the flat-top centre and rejects pile-up.
- Delivers timestamped events through a single-entry valid/ready output register to downstream readout.

---
 rtl/v5_filter_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_v5_filter_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/v5_filter_ctrl.sv
// Sequencer and event extractor for the v5 trapezoidal shaping filter: flushes and
// settles the filter, triggers on threshold, samples the flat top, rejects pile-up.
module v5_filter_ctrl #(
    parameter int DATA_W = 18,
    parameter int K_LEN  = 4,
    parameter int L_LEN  = 8,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic signed [DATA_W-1:0] filt_data,
    output logic                     filt_clr,
    output logic signed [DATA_W-1:0] evt_amp,
    output logic [TS_W-1:0]          evt_time,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [CNT_W-1:0]         pileup_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     busy
);

    generate
        if (K_LEN < 1 || L_LEN <= K_LEN) begin : g_bad_params
            $error("v5_filter_ctrl: K_LEN must be >= 1 and L_LEN must exceed K_LEN");
        end
    endgenerate

    localparam int WIN = K_LEN + L_LEN;
    localparam int MID = K_LEN + (L_LEN - K_LEN) / 2;
    localparam int CW  = $clog2(WIN + 1);

    localparam logic [CW-1:0] WIN_C = CW'(WIN);
    localparam logic [CW-1:0] SET_C = CW'(WIN - 1);
    localparam logic [CW-1:0] MID_C = CW'(MID);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FLUSH  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] ARMED  = 3'd3;
    localparam logic [2:0] WINDOW = 3'd4;
    localparam logic [2:0] REARM  = 3'd5;

    logic [2:0]               state_reg, state_next;
    logic [CW-1:0]            cnt_reg, cnt_next;
    logic [TS_W-1:0]          ts_reg;
    logic [TS_W-1:0]          t0_reg;
    logic signed [DATA_W-1:0] amp_reg;
    logic                     below_reg;
    logic                     pileup_reg;

    logic above;
    logic pileup_now;
    logic win_end;
    logic load_evt;
    logic load_pile;

    assign above      = filt_data > threshold;
    // The last window sample can itself complete a pile-up.
    assign pileup_now = pileup_reg | (above & below_reg);
    assign win_end    = enable && (state_reg == WINDOW) && (cnt_reg == WIN_C);
    assign load_evt   = win_end && !pileup_now;
    assign load_pile  = win_end && pileup_now;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = FLUSH;
                    cnt_next   = '0;
                end
                FLUSH: begin
                    if (cnt_reg == WIN_C) begin
                        state_next = SETTLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + ONE_C;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == SET_C) begin
                        state_next = ARMED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + ONE_C;
                    end
                end
                ARMED: begin
                    if (above) begin
                        state_next = WINDOW;
                        cnt_next   = ONE_C;
                    end
                end
                WINDOW: begin
                    if (cnt_reg == WIN_C) begin
                        state_next = REARM;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + ONE_C;
                    end
                end
                REARM: begin
                    if (!above) begin
                        state_next = ARMED;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            ts_reg     <= '0;
            t0_reg     <= '0;
            amp_reg    <= '0;
            below_reg  <= 1'b0;
            pileup_reg <= 1'b0;
            filt_clr   <= 1'b1;
            busy       <= 1'b0;
            evt_amp    <= '0;
            evt_time   <= '0;
            evt_valid  <= 1'b0;
            pileup_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ts_reg    <= ts_reg + 1'b1;
            filt_clr  <= (state_next == IDLE) || (state_next == FLUSH);
            busy      <= (state_next != IDLE) && (state_next != ARMED);

            if (enable && state_reg == ARMED && above) begin
                t0_reg     <= ts_reg;
                below_reg  <= 1'b0;
                pileup_reg <= 1'b0;
            end else if (state_reg == WINDOW) begin
                if (!above) begin
                    below_reg <= 1'b1;
                end
                if (above && below_reg) begin
                    pileup_reg <= 1'b1;
                end
                if (cnt_reg == MID_C) begin
                    amp_reg <= filt_data;
                end
            end

            // A load alongside a transfer replaces the departing event.
            if (load_evt) begin
                if (!evt_valid || evt_ready) begin
                    evt_amp   <= amp_reg;
                    evt_time  <= t0_reg;
                    evt_valid <= 1'b1;
                end else if (drop_cnt != {CNT_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            if (load_pile && pileup_cnt != {CNT_W{1'b1}}) begin
                pileup_cnt <= pileup_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_v5_filter_ctrl.sv
// Directed bench for v5_filter_ctrl: startup sequencing, pulse capture, pile-up,
// backpressure, simultaneous accept/load, abort, timestamp wrap and async reset.
module tb_v5_filter_ctrl;

    localparam int DATA_W = 18;
    localparam int K_LEN  = 4;
    localparam int L_LEN  = 8;
    localparam int TS_W   = 32;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic evt_ready = 1'b0;
    logic signed [DATA_W-1:0] threshold = 18'sd100;
    logic signed [DATA_W-1:0] filt_data = '0;
    logic filt_clr, evt_valid, busy;
    logic signed [DATA_W-1:0] evt_amp;
    logic [TS_W-1:0] evt_time;
    logic [CNT_W-1:0] pileup_cnt, drop_cnt;

    logic [31:0] cyc;
    logic [31:0] ts_base = '0;
    int errors = 0;
    int checks = 0;

    v5_filter_ctrl #(
        .DATA_W(DATA_W), .K_LEN(K_LEN), .L_LEN(L_LEN), .TS_W(TS_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
        .filt_data(filt_data), .filt_clr(filt_clr), .evt_amp(evt_amp),
        .evt_time(evt_time), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .pileup_cnt(pileup_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; plus ts_base this is the expected timestamp.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= '0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [31:0] ts_now();
        return cyc + ts_base;
    endfunction

    // Trapezoid relative to the trigger cycle; the pile-up variant dips then re-crosses.
    function automatic logic signed [DATA_W-1:0] shape(int j, int amp, bit pile);
        int v;
        if (pile && j == 9)        v = 50;
        else if (pile && j == 10)  v = 300;
        else if (pile && j > 10)   v = 0;
        else if (j < 0)            v = 0;
        else if (j <= 2)           v = amp * (j + 1) / 4;
        else if (j <= 7)           v = amp;
        else if (j <= 10)          v = amp * (11 - j) / 4;
        else                       v = 0;
        return DATA_W'(v);
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (filt_clr !== 1'b1) begin errors++; $display("FAIL reset_filt_clr: got %b want 1", filt_clr); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (evt_amp !== '0 || evt_time !== '0) begin errors++; $display("FAIL reset_evt_regs: got amp=%0d time=%0d want 0/0", evt_amp, evt_time); end
        checks++; if (pileup_cnt !== '0 || drop_cnt !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", pileup_cnt, drop_cnt); end
        reset  = 1'b0;
        enable = 1'b1;
        $display("reset: released, enable=1 at cycle 0");
    endtask

    task automatic test_startup();
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            checks++; if (filt_clr !== (i <= 13)) begin errors++; $display("FAIL startup_filt_clr cycle %0d: got %b want %b", i, filt_clr, (i <= 13)); end
            checks++; if (busy !== (i <= 25)) begin errors++; $display("FAIL startup_busy cycle %0d: got %b want %b", i, busy, (i <= 25)); end
        end
        $display("startup: flush/settle sequence walked to cycle 27");
    endtask

    task automatic test_single_pulse();
        repeat (500 - int'(cyc)) @(negedge clk);
        for (int j = 0; j <= 20; j++) begin
            if (j == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_window: got %b want 1", busy); end
            end
            if (j == 12) begin
                checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b want 0", evt_valid); end
            end
            if (j == 13) begin
                checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", evt_valid); end
                checks++; if (evt_amp !== DATA_W'(800)) begin errors++; $display("FAIL single_amp: got %0d want 800", evt_amp); end
                checks++; if (evt_time !== 32'd500) begin errors++; $display("FAIL single_time: got %0d want 500", evt_time); end
            end
            if (j == 14) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_rearmed: got %b want 0", busy); end
            end
            if (j == 16) begin
                checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_accepted: got %b want 0", evt_valid); end
                evt_ready = 1'b0;
            end
            if (j == 15) evt_ready = 1'b1;
            filt_data = shape(j, 800, 1'b0);
            @(negedge clk);
        end
        $display("single_pulse: amp=800 at ts=500 captured and accepted");
    endtask

    task automatic test_pileup();
        logic [31:0] t1;
        for (int j = 0; j <= 15; j++) begin
            if (j == 13) begin
                checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL pileup_no_event: got %b want 0", evt_valid); end
                checks++; if (pileup_cnt !== 16'd1) begin errors++; $display("FAIL pileup_cnt: got %0d want 1", pileup_cnt); end
            end
            filt_data = shape(j, 800, 1'b1);
            @(negedge clk);
        end
        t1 = ts_now();
        for (int j = 0; j <= 15; j++) begin
            if (j == 13) begin
                checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL pileup_next_valid: got %b want 1", evt_valid); end
                checks++; if (evt_amp !== DATA_W'(1000)) begin errors++; $display("FAIL pileup_next_amp: got %0d want 1000", evt_amp); end
                checks++; if (evt_time !== t1) begin errors++; $display("FAIL pileup_next_time: got %0d want %0d", evt_time, t1); end
                evt_ready = 1'b1;
            end
            if (j == 14) begin
                checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL pileup_next_accept: got %b want 0", evt_valid); end
                evt_ready = 1'b0;
            end
            filt_data = shape(j, 1000, 1'b0);
            @(negedge clk);
        end
        $display("pileup: rejected pulse counted, following pulse delivered");
    endtask

    task automatic test_backpressure();
        logic [31:0] ta;
        evt_ready = 1'b0;
        ta = ts_now();
        for (int j = 0; j <= 15; j++) begin
            filt_data = shape(j, 700, 1'b0);
            @(negedge clk);
        end
        for (int j = 0; j <= 15; j++) begin
            if (j == 13) begin
                checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b want 1", evt_valid); end
                checks++; if (evt_amp !== DATA_W'(700)) begin errors++; $display("FAIL bp_amp_held: got %0d want 700", evt_amp); end
                checks++; if (evt_time !== ta) begin errors++; $display("FAIL bp_time_held: got %0d want %0d", evt_time, ta); end
                checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_drop_cnt: got %0d want 1", drop_cnt); end
            end
            filt_data = shape(j, 900, 1'b0);
            @(negedge clk);
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_delivered: got %b want 0", evt_valid); end
        $display("backpressure: first event held, second dropped, first delivered");
    endtask

    task automatic test_back_to_back();
        logic [31:0] td;
        for (int j = 0; j <= 15; j++) begin
            if (j == 13) begin
                checks++; if (evt_amp !== DATA_W'(600)) begin errors++; $display("FAIL b2b_first_amp: got %0d want 600", evt_amp); end
            end
            filt_data = shape(j, 600, 1'b0);
            @(negedge clk);
        end
        td = ts_now();
        for (int j = 0; j <= 15; j++) begin
            if (j == 12) evt_ready = 1'b1;
            if (j == 13) begin
                evt_ready = 1'b0;
                checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", evt_valid); end
                checks++; if (evt_amp !== DATA_W'(500)) begin errors++; $display("FAIL b2b_amp: got %0d want 500", evt_amp); end
                checks++; if (evt_time !== td) begin errors++; $display("FAIL b2b_time: got %0d want %0d", evt_time, td); end
                checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL b2b_drop_cnt: got %0d want 1", drop_cnt); end
            end
            filt_data = shape(j, 500, 1'b0);
            @(negedge clk);
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", evt_valid); end
        $display("back_to_back: accept and load on the same cycle");
    endtask

    task automatic test_abort();
        for (int j = 0; j <= 15; j++) begin
            if (j == 5) enable = 1'b0;
            if (j == 6) begin
                checks++; if (filt_clr !== 1'b1) begin errors++; $display("FAIL abort_filt_clr: got %b want 1", filt_clr); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
            end
            if (j == 14) begin
                checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL abort_no_event: got %b want 0", evt_valid); end
                checks++; if (pileup_cnt !== 16'd1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL abort_counters: got %0d/%0d want 1/1", pileup_cnt, drop_cnt); end
            end
            filt_data = shape(j, 800, 1'b0);
            @(negedge clk);
        end
        enable = 1'b1;
        repeat (26) @(negedge clk);
        checks++; if (busy !== 1'b0 || filt_clr !== 1'b0) begin errors++; $display("FAIL abort_rearm: got busy=%b clr=%b want 0/0", busy, filt_clr); end
        $display("abort: window abandoned, sequencer restarted");
    endtask

    task automatic test_wrap();
        dut.ts_reg = 32'hFFFF_FFFA;
        ts_base = 32'hFFFF_FFFA - cyc;
        repeat (5) @(negedge clk);
        for (int j = 0; j <= 15; j++) begin
            if (j == 13) begin
                checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", evt_valid); end
                checks++; if (evt_time !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_time_max: got %h want ffffffff", evt_time); end
                evt_ready = 1'b1;
            end
            if (j == 14) evt_ready = 1'b0;
            filt_data = shape(j, 800, 1'b0);
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        for (int j = 0; j <= 15; j++) begin
            if (j == 13) begin
                checks++; if (evt_time !== 32'd20) begin errors++; $display("FAIL wrap_time_after: got %0d want 20", evt_time); end
            end
            filt_data = shape(j, 800, 1'b0);
            @(negedge clk);
        end
        $display("wrap: trigger at ffffffff and at 20 after wrap");
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j <= 5; j++) begin
            filt_data = shape(j, 800, 1'b0);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || filt_clr !== 1'b1) begin errors++; $display("FAIL midreset_ctrl: got busy=%b clr=%b want 0/1", busy, filt_clr); end
        checks++; if (evt_valid !== 1'b0 || evt_time !== '0) begin errors++; $display("FAIL midreset_evt: got valid=%b time=%0d want 0/0", evt_valid, evt_time); end
        checks++; if (pileup_cnt !== '0 || drop_cnt !== '0) begin errors++; $display("FAIL midreset_counters: got %0d/%0d want 0/0", pileup_cnt, drop_cnt); end
        filt_data = '0;
        @(negedge clk);
        reset = 1'b0;
        $display("reset_mid: asynchronous reset during window");
    endtask

    initial begin
        test_reset();
        test_startup();
        test_single_pulse();
        test_pileup();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
